// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Sequential Y86-64 fetch stage. Takes a PC, reads the instruction
//            one byte per memory handshake, decodes icode/ifun/rA/rB/valC and
//            computes valP, then presents the result on a valid/ready port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            clock, all state changes on posedge
//   rst_n          synchronous active-low reset
//   pc_in_i        next PC, accepted with pc_load_i while pc_ready_o=1
//   pc_load_i      pc_in_i valid
//   pc_ready_o     high while idle
//   mem_req_o      byte read request
//   mem_addr_o     byte address, held until mem_ack_i
//   mem_rdata_i    read byte, sampled with mem_ack_i
//   mem_ack_i      completes the current request
//   icode_o/ifun_o instruction code and function
//   rA_o/rB_o      register specifiers, 4'hF when absent
//   valC_o         little-endian constant, 0 when absent
//   valP_o         pc + instruction length
//   instr_valid_o  result valid, held until instr_ready_i
//   instr_ready_i  downstream accept
//   imem_error_o   fetch address beyond instruction memory
//   instr_inv_o    illegal icode (or ifun when checking is enabled)
// Configuration
//   FETCH_IFUN_CHECK_EN  when defined, illegal ifun values also raise
//                        instr_inv_o; otherwise only icode > 4'hB does.
// ============================================================================
module instr_fetch_unit #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in_i,
  input  logic              pc_load_i,
  output logic              pc_ready_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [3:0]        icode_o,
  output logic [3:0]        ifun_o,
  output logic [3:0]        rA_o,
  output logic [3:0]        rB_o,
  output logic [ADDR_W-1:0] valC_o,
  output logic [ADDR_W-1:0] valP_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic              imem_error_o,
  output logic              instr_inv_o
);

  // Address limit widened by one bit so pc+k is compared without wrapping.
  localparam logic [ADDR_W:0] c_MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [3:0]      c_NO_REG    = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BYTE0 = 3'd1,
    S_REGS  = 3'd2,
    S_CONST = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [3:0]          k_q;          // bytes acked so far
  logic [2:0]          cidx_q;       // next valC byte index
  logic [3:0]          len_q;        // instruction length from icode
  logic                need_const_q;
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [3:0]          icode_q;
  logic [3:0]          ifun_q;
  logic [3:0]          ra_q;
  logic [3:0]          rb_q;
  logic [ADDR_W-1:0]   valc_q;
  logic [ADDR_W-1:0]   valp_q;
  logic                valid_q;
  logic                err_q;
  logic                inv_q;

  logic [3:0]          w_k_inc;
  logic [ADDR_W:0]     w_next_sum;
  logic                w_next_oor;
  logic [ADDR_W-1:0]   w_next_addr;
  logic                w_load_oor;
  logic [3:0]          w_b0_icode;
  logic [3:0]          w_b0_ifun;
  logic                w_b0_ill;
  logic                w_b0_regs;
  logic                w_b0_const;
  logic [3:0]          w_b0_len;
  logic                w_ifun_bad;
  logic [ADDR_W-1:0]   w_valp_b0;
  logic [ADDR_W-1:0]   w_valp_len;

  // Address of the byte that would be requested after the current ack.
  assign w_k_inc     = k_q + 4'd1;
  assign w_next_sum  = {1'b0, pc_q} + (ADDR_W+1)'(w_k_inc);
  assign w_next_oor  = (w_next_sum >= c_MEM_LIMIT);
  assign w_next_addr = w_next_sum[ADDR_W-1:0];
  assign w_load_oor  = ({1'b0, pc_in_i} >= c_MEM_LIMIT);

  assign w_b0_icode  = mem_rdata_i[7:4];
  assign w_b0_ifun   = mem_rdata_i[3:0];
  assign w_b0_ill    = (w_b0_icode > 4'hB);

  always_comb begin
    w_b0_regs  = 1'b0;
    w_b0_const = 1'b0;
    w_b0_len   = 4'd1;
    case (w_b0_icode)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        w_b0_regs = 1'b1;
        w_b0_len  = 4'd2;
      end
      4'h3, 4'h4, 4'h5: begin
        w_b0_regs  = 1'b1;
        w_b0_const = 1'b1;
        w_b0_len   = 4'd10;
      end
      4'h7, 4'h8: begin
        w_b0_const = 1'b1;
        w_b0_len   = 4'd9;
      end
      default: begin
        w_b0_len = 4'd1;
      end
    endcase
  end

`ifdef FETCH_IFUN_CHECK_EN
  always_comb begin
    w_ifun_bad = 1'b0;
    case (w_b0_icode)
      4'h6:       w_ifun_bad = (w_b0_ifun > 4'h3);
      4'h2, 4'h7: w_ifun_bad = (w_b0_ifun > 4'h6);
      default:    w_ifun_bad = (w_b0_ifun != 4'h0);
    endcase
  end
`else
  assign w_ifun_bad = 1'b0;
`endif

  assign w_valp_b0  = pc_q + ADDR_W'(w_b0_len);
  assign w_valp_len = pc_q + ADDR_W'(len_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      k_q          <= '0;
      cidx_q       <= '0;
      len_q        <= '0;
      need_const_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      icode_q      <= '0;
      ifun_q       <= '0;
      ra_q         <= c_NO_REG;
      rb_q         <= c_NO_REG;
      valc_q       <= '0;
      valp_q       <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      inv_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pc_load_i) begin
            pc_q    <= pc_in_i;
            k_q     <= '0;
            cidx_q  <= '0;
            icode_q <= '0;
            ifun_q  <= '0;
            ra_q    <= c_NO_REG;
            rb_q    <= c_NO_REG;
            valc_q  <= '0;
            err_q   <= 1'b0;
            inv_q   <= 1'b0;
            if (w_load_oor) begin
              // First byte already out of range: report a nop with error.
              state_q <= S_DONE;
              valid_q <= 1'b1;
              err_q   <= 1'b1;
              icode_q <= 4'h1;
              valp_q  <= pc_in_i;
            end else begin
              state_q    <= S_BYTE0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= pc_in_i;
            end
          end
        end

        S_BYTE0: begin
          if (mem_ack_i) begin
            icode_q      <= w_b0_icode;
            ifun_q       <= w_b0_ifun;
            k_q          <= w_k_inc;
            len_q        <= w_b0_len;
            need_const_q <= w_b0_const;
            inv_q        <= w_b0_ill | w_ifun_bad;
            if (w_b0_ill || !(w_b0_regs || w_b0_const)) begin
              state_q   <= S_DONE;
              mem_req_q <= 1'b0;
              valid_q   <= 1'b1;
              valp_q    <= w_valp_b0;
            end else if (w_next_oor) begin
              state_q   <= S_DONE;
              mem_req_q <= 1'b0;
              valid_q   <= 1'b1;
              err_q     <= 1'b1;
              inv_q     <= 1'b0;
              icode_q   <= 4'h1;
              ifun_q    <= 4'h0;
              valp_q    <= pc_q;
            end else begin
              state_q    <= w_b0_regs ? S_REGS : S_CONST;
              mem_addr_q <= w_next_addr;
            end
          end
        end

        S_REGS: begin
          if (mem_ack_i) begin
            ra_q <= mem_rdata_i[7:4];
            rb_q <= mem_rdata_i[3:0];
            k_q  <= w_k_inc;
            if (!need_const_q) begin
              state_q   <= S_DONE;
              mem_req_q <= 1'b0;
              valid_q   <= 1'b1;
              valp_q    <= w_valp_len;
            end else if (w_next_oor) begin
              state_q   <= S_DONE;
              mem_req_q <= 1'b0;
              valid_q   <= 1'b1;
              err_q     <= 1'b1;
              inv_q     <= 1'b0;
              icode_q   <= 4'h1;
              ifun_q    <= 4'h0;
              ra_q      <= c_NO_REG;
              rb_q      <= c_NO_REG;
              valp_q    <= pc_q;
            end else begin
              state_q    <= S_CONST;
              mem_addr_q <= w_next_addr;
            end
          end
        end

        S_CONST: begin
          if (mem_ack_i) begin
            valc_q[{cidx_q, 3'b000} +: 8] <= mem_rdata_i;
            k_q    <= w_k_inc;
            cidx_q <= cidx_q + 3'd1;
            if (cidx_q == 3'd7) begin
              state_q   <= S_DONE;
              mem_req_q <= 1'b0;
              valid_q   <= 1'b1;
              valp_q    <= w_valp_len;
            end else if (w_next_oor) begin
              state_q   <= S_DONE;
              mem_req_q <= 1'b0;
              valid_q   <= 1'b1;
              err_q     <= 1'b1;
              inv_q     <= 1'b0;
              icode_q   <= 4'h1;
              ifun_q    <= 4'h0;
              ra_q      <= c_NO_REG;
              rb_q      <= c_NO_REG;
              valc_q    <= '0;
              valp_q    <= pc_q;
            end else begin
              mem_addr_q <= w_next_addr;
            end
          end
        end

        S_DONE: begin
          if (instr_ready_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pc_ready_o    = (state_q == S_IDLE);
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign icode_o       = icode_q;
  assign ifun_o        = ifun_q;
  assign rA_o          = ra_q;
  assign rB_o          = rb_q;
  assign valC_o        = valc_q;
  assign valP_o        = valp_q;
  assign instr_valid_o = valid_q;
  assign imem_error_o  = err_q;
  assign instr_inv_o   = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit with a byte
//            memory responder and an expected-result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int MEM_BYTES = 1024;

  logic        clk;
  logic        rst_n;
  logic [63:0] pc_in_i;
  logic        pc_load_i;
  logic        pc_ready_o;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_ack_i;
  logic [3:0]  icode_o, ifun_o, rA_o, rB_o;
  logic [63:0] valC_o, valP_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        imem_error_o;
  logic        instr_inv_o;

  instr_fetch_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_in_i       (pc_in_i),
    .pc_load_i     (pc_load_i),
    .pc_ready_o    (pc_ready_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rdata_i   (mem_rdata_i),
    .mem_ack_i     (mem_ack_i),
    .icode_o       (icode_o),
    .ifun_o        (ifun_o),
    .rA_o          (rA_o),
    .rB_o          (rB_o),
    .valC_o        (valC_o),
    .valP_o        (valP_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .imem_error_o  (imem_error_o),
    .instr_inv_o   (instr_inv_o)
  );

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        err;
    logic        inv;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem [0:MEM_BYTES-1];
  int          n_vec = 0;
  int          n_err = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          ack_cnt = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [63:0] prev_addr = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Byte memory: acks after ack_delay idle request cycles, checks address
  // stability while waiting and that no request leaves the memory range.
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && prev_req && !prev_ack && mem_req_o)
        chk("addr_stable", mem_addr_o, prev_addr);
      if (mem_req_o)
        chk("addr_in_range", 64'(mem_addr_o < 64'(MEM_BYTES)), 64'd1);
      prev_req  = mem_req_o;
      prev_addr = mem_addr_o;
      if (mem_req_o && rst_n && wait_cnt >= ack_delay) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem[mem_addr_o[9:0]];
        wait_cnt    = 0;
        ack_cnt++;
      end else begin
        mem_ack_i = 1'b0;
        if (mem_req_o) wait_cnt++;
        else wait_cnt = 0;
      end
      prev_ack = mem_ack_i;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [63:0] vc, input logic [63:0] vp,
                              input logic er, input logic iv);
    exp_t e;
    e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
    e.valc = vc; e.valp = vp; e.err = er; e.inv = iv;
    sb.push_back(e);
  endtask

  task automatic load_pc(input logic [63:0] pc);
    pc_in_i   = pc;
    pc_load_i = 1'b1;
    step();
    pc_load_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max, output int cyc);
    cyc = 1;
    while (!instr_valid_o && cyc < max) begin
      step();
      cyc++;
    end
    chk({tag, "_valid"}, 64'(instr_valid_o), 64'd1);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    n_vec++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL %s_sb: observed empty queue, expected an entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_icode"}, 64'(icode_o), 64'(e.icode));
      chk({tag, "_ifun"},  64'(ifun_o),  64'(e.ifun));
      chk({tag, "_rA"},    64'(rA_o),    64'(e.ra));
      chk({tag, "_rB"},    64'(rB_o),    64'(e.rb));
      chk({tag, "_valC"},  valC_o,       e.valc);
      chk({tag, "_valP"},  valP_o,       e.valp);
      chk({tag, "_err"},   64'(imem_error_o), 64'(e.err));
      chk({tag, "_inv"},   64'(instr_inv_o),  64'(e.inv));
    end
  endtask

  task automatic release_out(input string tag);
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    chk({tag, "_rel_valid"}, 64'(instr_valid_o), 64'd0);
    chk({tag, "_rel_ready"}, 64'(pc_ready_o), 64'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pc_ready"}, 64'(pc_ready_o), 64'd1);
    chk({tag, "_mem_req"},  64'(mem_req_o), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 64'd0);
    chk({tag, "_valid"},    64'(instr_valid_o), 64'd0);
    chk({tag, "_icode"},    64'(icode_o), 64'd0);
    chk({tag, "_ifun"},     64'(ifun_o), 64'd0);
    chk({tag, "_rA"},       64'(rA_o), 64'hF);
    chk({tag, "_rB"},       64'(rB_o), 64'hF);
    chk({tag, "_valC"},     valC_o, 64'd0);
    chk({tag, "_valP"},     valP_o, 64'd0);
    chk({tag, "_err"},      64'(imem_error_o), 64'd0);
    chk({tag, "_inv"},      64'(instr_inv_o), 64'd0);
  endtask

  initial begin
    int cyc;
    logic [63:0] held_valp;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    rst_n         = 1'b0;
    pc_in_i       = '0;
    pc_load_i     = 1'b0;
    instr_ready_i = 1'b0;
    step();
    step();
    check_reset("reset");
    rst_n = 1'b1;
    step();

    // irmovq $10,%rbx with ack tied high: 11 cycles to valid.
    mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h0A;
    ack_delay = 0;
    expect_instr(4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'd10, 1'b0, 1'b0);
    load_pc(64'd0);
    wait_valid("irmov", 50, cyc);
    chk("irmov_latency", 64'(cyc), 64'd11);
    check_out("irmov");
    release_out("irmov");

    // jmp 0x100 from 0x20 with two wait cycles per byte.
    mem[8'h20] = 8'h70; mem[8'h21] = 8'h00; mem[8'h22] = 8'h01;
    ack_delay = 2;
    expect_instr(4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'h29, 1'b0, 1'b0);
    load_pc(64'h20);
    wait_valid("jmp", 100, cyc);
    check_out("jmp");
    release_out("jmp");
    ack_delay = 0;

    // cmovle-style 2-byte instruction.
    mem[8'h40] = 8'h21; mem[8'h41] = 8'h34;
    expect_instr(4'h2, 4'h1, 4'h3, 4'h4, 64'd0, 64'h42, 1'b0, 1'b0);
    load_pc(64'h40);
    wait_valid("cmov", 50, cyc);
    check_out("cmov");
    release_out("cmov");

    // irmovq straddling the end of memory: two bytes then error.
    mem[MEM_BYTES-2] = 8'h30; mem[MEM_BYTES-1] = 8'hF3;
    ack_cnt = 0;
    expect_instr(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'(MEM_BYTES-2), 1'b1, 1'b0);
    load_pc(64'(MEM_BYTES-2));
    wait_valid("edge", 50, cyc);
    check_out("edge");
    chk("edge_acks", 64'(ack_cnt), 64'd2);
    release_out("edge");

    // PC beyond memory, including the top of the 64-bit space.
    ack_cnt = 0;
    expect_instr(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd2000, 1'b1, 1'b0);
    load_pc(64'd2000);
    wait_valid("oor", 20, cyc);
    check_out("oor");
    release_out("oor");
    expect_instr(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    load_pc(64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid("oor_top", 20, cyc);
    check_out("oor_top");
    chk("oor_acks", 64'(ack_cnt), 64'd0);
    release_out("oor_top");

    // Illegal icode.
    mem[0] = 8'hC0;
    expect_instr(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b0, 1'b1);
    load_pc(64'd0);
    wait_valid("badicode", 20, cyc);
    check_out("badicode");
    release_out("badicode");

    // OPq with ifun 4: illegal only when ifun checking is built in.
    mem[0] = 8'h64; mem[1] = 8'h12;
`ifdef FETCH_IFUN_CHECK_EN
    expect_instr(4'h6, 4'h4, 4'h1, 4'h2, 64'd0, 64'd2, 1'b0, 1'b1);
`else
    expect_instr(4'h6, 4'h4, 4'h1, 4'h2, 64'd0, 64'd2, 1'b0, 1'b0);
`endif
    load_pc(64'd0);
    wait_valid("ifun", 20, cyc);
    check_out("ifun");
    release_out("ifun");

    // Back-pressure: outputs frozen and pc_load ignored while not accepted.
    mem[8'h50] = 8'h10;
    expect_instr(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h51, 1'b0, 1'b0);
    load_pc(64'h50);
    wait_valid("stall", 20, cyc);
    check_out("stall");
    held_valp = 64'h51;
    for (int i = 0; i < 5; i++) begin
      pc_in_i   = 64'h60;
      pc_load_i = 1'b1;
      step();
      chk("stall_valid", 64'(instr_valid_o), 64'd1);
      chk("stall_valP",  valP_o, held_valp);
      chk("stall_ready", 64'(pc_ready_o), 64'd0);
      chk("stall_req",   64'(mem_req_o), 64'd0);
    end
    pc_load_i = 1'b0;
    release_out("stall");
    mem[8'h60] = 8'h00;
    expect_instr(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h61, 1'b0, 1'b0);
    load_pc(64'h60);
    wait_valid("halt", 20, cyc);
    check_out("halt");
    release_out("halt");

    // Reset during the constant fetch of an irmovq.
    mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h0A; mem[3] = 8'h00;
    load_pc(64'd0);
    step();
    step();
    step();
    chk("midrst_busy", 64'(mem_req_o), 64'd1);
    rst_n = 1'b0;
    step();
    check_reset("midrst");
    rst_n = 1'b1;
    step();
    chk("midrst_req_after", 64'(mem_req_o), 64'd0);

    // Recovery fetch after reset.
    mem[8'h70] = 8'h90;
    expect_instr(4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'h71, 1'b0, 1'b0);
    load_pc(64'h70);
    wait_valid("ret", 20, cyc);
    check_out("ret");
    release_out("ret");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
